// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit ISA multicycle core: opcodes, FSM states, IR field positions.
package cpu10_pkg;

    localparam int IR_W  = 10;
    localparam int OP_HI = 9;
    localparam int OP_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 3;
    localparam int RS_HI = 2;
    localparam int RS_LO = 0;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JR   = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_LI   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8 x DATA_W register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
module cpu_regfile #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [2:0]        w_addr,
    input  logic [DATA_W-1:0] w_data
);

    logic [DATA_W-1:0] r_regs [0:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (w_addr != 3'd0)) begin
            r_regs[w_addr] <= w_data;
        end
    end

    assign ra_data = (ra_addr == 3'd0) ? '0 : r_regs[ra_addr];
    assign rb_data = (rb_addr == 3'd0) ? '0 : r_regs[rb_addr];

endmodule

// File: rtl/cpu_multicycle_core.sv
// Multicycle core for the 10-bit ISA with req/ready instruction and data memories.
// Define CPU_TRACE_EN to add the trace_valid/trace_pc/trace_wdata retire port.
//
// state   | meaning
// FETCH   | imem_req high, wait for imem_ready, latch IR
// EXEC    | decode, ALU, branches resolved, data access set up
// MEM     | dmem_req high, hold addr/we/wdata until dmem_ready
// WB      | one-cycle register write, PC advance
// HALT    | terminal, no requests until reset
module cpu_multicycle_core
    import cpu10_pkg::*;
#(
    parameter int          DATA_W   = 10,
    parameter int          PC_W     = 10,
    parameter int          DADDR_W  = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [9:0]         imem_rdata,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
`ifdef CPU_TRACE_EN
    output logic               trace_valid,
    output logic [PC_W-1:0]    trace_pc,
    output logic [DATA_W-1:0]  trace_wdata,
`endif
    output logic               done,
    output logic               illegal
);

    state_t              r_state;
    state_t              w_next;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_npc;
    logic [IR_W-1:0]     r_ir;
    logic [2:0]          r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_dmem_we;
    logic [DADDR_W-1:0]  r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_done;
    logic                r_illegal;

    logic [3:0]          w_op;
    logic [2:0]          w_rd;
    logic [2:0]          w_rs;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_imm_d;
    logic [DATA_W-1:0]   w_imm_z;
    logic [PC_W-1:0]     w_imm_p;
    logic [PC_W-1:0]     w_pc1;
    logic [PC_W-1:0]     w_a_pc;
    logic [DADDR_W-1:0]  w_b_addr;
    logic [DATA_W-1:0]   w_alu;
    logic                w_rf_we;

    assign w_op     = r_ir[OP_HI:OP_LO];
    assign w_rd     = r_ir[RD_HI:RD_LO];
    assign w_rs     = r_ir[RS_HI:RS_LO];
    assign w_imm_d  = {{(DATA_W-3){w_rs[2]}}, w_rs};
    assign w_imm_z  = {{(DATA_W-3){1'b0}}, w_rs};
    assign w_imm_p  = {{(PC_W-3){w_rs[2]}}, w_rs};
    assign w_pc1    = r_pc + PC_W'(1);
    assign w_a_pc   = PC_W'(w_a);
    assign w_b_addr = DADDR_W'(w_b);
    assign w_rf_we  = (r_state == S_WB);

    cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst_n   (reset),
        .ra_addr (w_rd),
        .ra_data (w_a),
        .rb_addr (w_rs),
        .rb_data (w_b),
        .we      (w_rf_we),
        .w_addr  (r_waddr),
        .w_data  (r_wdata)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            OP_ADDI: w_alu = w_a + w_imm_d;
            OP_LI:   w_alu = w_imm_z;
            OP_JAL:  w_alu = DATA_W'(w_pc1);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (imem_ready) w_next = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_LD, OP_ST:    w_next = S_MEM;
                    OP_BEQZ, OP_JR:  w_next = S_FETCH;
                    OP_HALT:         w_next = S_HALT;
                    default:         w_next = op_is_illegal(w_op) ? S_HALT : S_WB;
                endcase
            end
            S_MEM:   if (dmem_ready) w_next = r_dmem_we ? S_FETCH : S_WB;
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // PC holds the current instruction's address until it retires; r_npc carries the successor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= PC_W'(RESET_PC);
            r_npc        <= '0;
            r_ir         <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (imem_ready) r_ir <= imem_rdata;
                S_EXEC: begin
                    r_npc   <= w_pc1;
                    r_waddr <= w_rd;
                    r_wdata <= w_alu;
                    case (w_op)
                        OP_JAL: begin
                            r_waddr <= 3'd7;
                            r_npc   <= w_a_pc;
                        end
                        OP_LD, OP_ST: begin
                            r_dmem_addr  <= w_b_addr;
                            r_dmem_we    <= (w_op == OP_ST);
                            r_dmem_wdata <= w_a;
                        end
                        OP_BEQZ: r_pc <= (w_a == '0) ? (w_pc1 + w_imm_p) : w_pc1;
                        OP_JR:   r_pc <= w_a_pc;
                        OP_HALT: r_done <= 1'b1;
                        default: begin
                            if (op_is_illegal(w_op)) begin
                                r_done    <= 1'b1;
                                r_illegal <= 1'b1;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (r_dmem_we) begin
                            r_pc      <= r_npc;
                            r_dmem_we <= 1'b0;
                        end else begin
                            r_wdata <= dmem_rdata;
                        end
                    end
                end
                S_WB:    r_pc <= r_npc;
                default: ;
            endcase
        end
    end

    // Gating with reset drops the fetch request the moment reset asserts.
    assign imem_req   = reset && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign done       = r_done;
    assign illegal    = r_illegal;

`ifdef CPU_TRACE_EN
    logic w_retire;

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_WB:    w_retire = 1'b1;
            S_MEM:   w_retire = dmem_ready && r_dmem_we;
            S_EXEC:  w_retire = (w_op == OP_BEQZ) || (w_op == OP_JR) || (w_op == OP_HALT);
            default: w_retire = 1'b0;
        endcase
    end

    assign trace_valid = w_retire;
    assign trace_pc    = r_pc;
    assign trace_wdata = (r_state == S_WB) ? r_wdata : '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Self-checking bench for cpu_multicycle_core: memory models with programmable wait states,
// fetch/data-access logging, a data-access scoreboard and a table of ALU vectors.
module tb_cpu_multicycle_core;
    import cpu10_pkg::*;

    localparam int DATA_W  = 10;
    localparam int PC_W    = 10;
    localparam int DADDR_W = 10;
    localparam int LOGN    = 4096;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [9:0]         imem_rdata = '0;
    logic               imem_ready = 1'b0;
    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata = '0;
    logic               dmem_ready = 1'b0;
    logic               done;
    logic               illegal;
`ifdef CPU_TRACE_EN
    logic               trace_valid;
    logic [PC_W-1:0]    trace_pc;
    logic [DATA_W-1:0]  trace_wdata;
    logic [DATA_W-1:0]  tr_pc2 = '0;
`endif

    cpu_multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
`ifdef CPU_TRACE_EN
        .trace_valid(trace_valid),
        .trace_pc   (trace_pc),
        .trace_wdata(trace_wdata),
`endif
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [9:0]        imem    [0:1023];
    logic [DATA_W-1:0] dm_init [0:1023];
    logic [DATA_W-1:0] dm_st   [0:1023];
    int                dm_tag  [0:1023];
    int                test_id = 0;
    int                imem_wait = 0;
    int                dmem_wait = 0;
    int                i_cnt = 0;
    int                d_cnt = 0;
    logic              d_active = 1'b0;
    logic              d_stable = 1'b1;
    logic              d_we0;
    logic [DADDR_W-1:0] d_addr0;
    logic [DATA_W-1:0] d_wd0;

    function automatic logic [DATA_W-1:0] dm_read(input logic [DADDR_W-1:0] a);
        return (dm_tag[a] == test_id) ? dm_st[a] : dm_init[a];
    endfunction

    always @(negedge clk) begin
        if (imem_req) begin
            if (i_cnt >= imem_wait) begin
                imem_ready = 1'b1;
                imem_rdata = imem[imem_addr];
            end else begin
                imem_ready = 1'b0;
                i_cnt++;
            end
        end else begin
            imem_ready = 1'b0;
            i_cnt = 0;
        end
        if (dmem_req) begin
            if (!d_active) begin
                d_active = 1'b1;
                d_stable = 1'b1;
                d_we0    = dmem_we;
                d_addr0  = dmem_addr;
                d_wd0    = dmem_wdata;
            end else if (dmem_we !== d_we0 || dmem_addr !== d_addr0 || dmem_wdata !== d_wd0) begin
                d_stable = 1'b0;
            end
            if (d_cnt >= dmem_wait) begin
                dmem_ready = 1'b1;
                dmem_rdata = dm_read(dmem_addr);
            end else begin
                dmem_ready = 1'b0;
                d_cnt++;
            end
        end else begin
            dmem_ready = 1'b0;
            d_cnt = 0;
            d_active = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int                 cyc = 0;
    int                 n_fetch = 0;
    int                 n_acc = 0;
    logic [PC_W-1:0]    f_addr [0:LOGN-1];
    int                 f_cyc  [0:LOGN-1];
    logic               a_we   [0:LOGN-1];
    logic [DADDR_W-1:0] a_addr [0:LOGN-1];
    logic [DATA_W-1:0]  a_data [0:LOGN-1];
    logic               a_stab [0:LOGN-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && imem_req && imem_ready) begin
            if (n_fetch < LOGN) begin
                f_addr[n_fetch] <= imem_addr;
                f_cyc[n_fetch]  <= cyc;
            end
            n_fetch <= n_fetch + 1;
        end
        if (reset && dmem_req && dmem_ready) begin
            if (n_acc < LOGN) begin
                a_we[n_acc]   <= dmem_we;
                a_addr[n_acc] <= dmem_addr;
                a_data[n_acc] <= dmem_wdata;
                a_stab[n_acc] <= d_stable && (dmem_we === d_we0) && (dmem_addr === d_addr0)
                                 && (dmem_wdata === d_wd0);
            end
            if (dmem_we) begin
                dm_st[dmem_addr]  <= dmem_wdata;
                dm_tag[dmem_addr] <= test_id;
            end
            n_acc <= n_acc + 1;
        end
`ifdef CPU_TRACE_EN
        if (trace_valid && trace_pc == 2) tr_pc2 <= trace_wdata;
`endif
    end

    // ---------------- checking ----------------
    typedef struct {
        logic               we;
        logic [DADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } acc_t;

    typedef struct {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] exp;
    } vec_t;

    acc_t exp_q[$];
    vec_t vecs[10];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   f0 = 0;
    int   a0 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    endtask

    function automatic logic [9:0] ins(input logic [3:0] op, input int rd, input int rs);
        return {op, 3'(rd), 3'(rs)};
    endfunction

    function automatic int fcyc(input int k);
        return (f0 + k < n_fetch && f0 + k < LOGN) ? f_cyc[f0 + k] : -1000;
    endfunction

    function automatic int faddr(input int k);
        return (f0 + k < n_fetch && f0 + k < LOGN) ? int'(f_addr[f0 + k]) : -1;
    endfunction

    task automatic rst_on();
        @(negedge clk);
        reset = 1'b0;
        test_id++;
        imem_wait = 0;
        dmem_wait = 0;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            imem[i]    = {OP_HALT, 6'd0};
            dm_init[i] = '0;
        end
    endtask

    task automatic rst_off();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        f0 = n_fetch;
        a0 = n_acc;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        for (int i = 0; i < maxc && !done; i++) @(negedge clk);
        chk({nm, " done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_fetch(input string nm, input int n, input int maxc);
        for (int i = 0; i < maxc && (n_fetch - f0) < n; i++) @(negedge clk);
        chk({nm, " fetch count"}, 32'(n_fetch - f0), 32'(n));
    endtask

    task automatic check_accs(input string nm);
        acc_t e;
        int   k;
        chk({nm, " access count"}, 32'(n_acc - a0), 32'(exp_q.size()));
        k = a0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (k < n_acc && k < LOGN) begin
                chk($sformatf("%s acc%0d we", nm, k - a0), 32'(a_we[k]), 32'(e.we));
                chk($sformatf("%s acc%0d addr", nm, k - a0), 32'(a_addr[k]), 32'(e.addr));
                chk($sformatf("%s acc%0d stable", nm, k - a0), 32'(a_stab[k]), 32'd1);
                if (e.we) chk($sformatf("%s acc%0d data", nm, k - a0), 32'(a_data[k]), 32'(e.data));
            end
            k++;
        end
    endtask

    initial begin
        vecs[0] = '{OP_ADD,  10'h3FF, 10'h002, 10'h001};
        vecs[1] = '{OP_SUB,  10'h005, 10'h007, 10'h3FE};
        vecs[2] = '{OP_AND,  10'h2AA, 10'h0FF, 10'h0AA};
        vecs[3] = '{OP_OR,   10'h200, 10'h011, 10'h211};
        vecs[4] = '{OP_SLT,  10'h3FF, 10'h001, 10'h001};
        vecs[5] = '{OP_SLT,  10'h001, 10'h3FF, 10'h000};
        vecs[6] = '{OP_SLT,  10'h200, 10'h1FF, 10'h001};
        vecs[7] = '{OP_ADDI, 10'h3FF, 10'h007, 10'h3FE};
        vecs[8] = '{OP_ADDI, 10'h1FE, 10'h003, 10'h201};
        vecs[9] = '{OP_LI,   10'h123, 10'h005, 10'h005};

        // 1: reset mid-fetch and mid data access
        rst_on();
        imem_wait = 1000;
        rst_off();
        repeat (5) @(negedge clk);
        chk("t1 req before reset", 32'(imem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t1 imem_req in reset", 32'(imem_req), 32'd0);
        chk("t1 done in reset", 32'(done), 32'd0);
        rst_on();
        dmem_wait = 1000;
        imem[0] = ins(OP_LI, 1, 1);
        imem[1] = ins(OP_LD, 2, 1);
        rst_off();
        repeat (8) @(negedge clk);
        chk("t1 dmem_req stalled", 32'(dmem_req), 32'd1);
        chk("t1 dmem_addr stalled", 32'(dmem_addr), 32'd1);
        chk("t1 pc at LD", 32'(imem_addr), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t1 dmem_req in reset", 32'(dmem_req), 32'd0);
        chk("t1 dmem_addr in reset", 32'(dmem_addr), 32'd0);
        chk("t1 pc in reset", 32'(imem_addr), 32'd0);
        chk("t1 imem_req in reset2", 32'(imem_req), 32'd0);
        chk("t1 done in reset2", 32'(done), 32'd0);

        // 2: LI/LI/ADD then store the sum
        rst_on();
        imem[0] = ins(OP_LI, 1, 3);
        imem[1] = ins(OP_LI, 2, 5);
        imem[2] = ins(OP_ADD, 1, 2);
        imem[3] = ins(OP_ST, 1, 0);
        exp_q.push_back('{1'b1, 10'd0, 10'd8});
        rst_off();
        wait_done("t2", 200);
        chk("t2 ADD latency", 32'(fcyc(3) - fcyc(2)), 32'd3);
        chk("t2 illegal", 32'(illegal), 32'd0);
        check_accs("t2");
`ifdef CPU_TRACE_EN
        chk("t2 trace ADD wdata", 32'(tr_pc2), 32'd8);
`endif

        // 3: ADDI wrap to all-ones, signed SLT against r0
        rst_on();
        imem[0] = ins(OP_LI, 1, 0);
        imem[1] = ins(OP_ADDI, 1, 7);
        imem[2] = ins(OP_ST, 1, 0);
        imem[3] = ins(OP_SLT, 1, 0);
        imem[4] = ins(OP_ST, 1, 0);
        exp_q.push_back('{1'b1, 10'd0, 10'h3FF});
        exp_q.push_back('{1'b1, 10'd0, 10'h001});
        rst_off();
        wait_done("t3", 200);
        check_accs("t3");

        // 4: store/load with a slow data memory
        rst_on();
        dmem_wait = 5;
        imem[0] = ins(OP_LI, 1, 6);
        imem[1] = ins(OP_LI, 2, 3);
        imem[2] = ins(OP_ST, 1, 2);
        imem[3] = ins(OP_LD, 4, 2);
        imem[4] = ins(OP_ST, 4, 0);
        exp_q.push_back('{1'b1, 10'd3, 10'd6});
        exp_q.push_back('{1'b0, 10'd3, 10'd0});
        exp_q.push_back('{1'b1, 10'd0, 10'd6});
        rst_off();
        wait_done("t4", 300);
        chk("t4 ST latency with waits", 32'(fcyc(3) - fcyc(2)), 32'd8);
        chk("t4 LD latency with waits", 32'(fcyc(4) - fcyc(3)), 32'd9);
        check_accs("t4");

        // 5a: PC reaches the top address and a non-branch wraps to 0
        rst_on();
        imem[0]    = ins(OP_LI, 1, 0);
        imem[1]    = ins(OP_ADDI, 1, 7);
        imem[2]    = ins(OP_JR, 1, 0);
        imem[1023] = ins(OP_LI, 2, 1);
        rst_off();
        wait_fetch("t5a", 5, 100);
        chk("t5a JR target", 32'(faddr(3)), 32'd1023);
        chk("t5a wrap to 0", 32'(faddr(4)), 32'd0);
        chk("t5a JR latency", 32'(fcyc(3) - fcyc(2)), 32'd2);

        // 5b: BEQZ backwards across 0
        rst_on();
        imem[0] = ins(OP_BEQZ, 0, 6);
        rst_off();
        wait_done("t5b", 100);
        chk("t5b branch target", 32'(faddr(1)), 32'd1023);
        chk("t5b BEQZ latency", 32'(fcyc(1) - fcyc(0)), 32'd2);

        // 6: reserved opcode stops the core
        rst_on();
        imem[0] = ins(4'hD, 0, 0);
        rst_off();
        wait_done("t6", 100);
        chk("t6 illegal", 32'(illegal), 32'd1);
        repeat (10) @(negedge clk);
        chk("t6 no more fetches", 32'(n_fetch - f0), 32'd1);
        chk("t6 imem_req low", 32'(imem_req), 32'd0);

        // ALU vector table: operands loaded from data memory, result stored to M[0]
        for (int v = 0; v < 10; v++) begin
            rst_on();
            dm_init[1] = vecs[v].a;
            dm_init[2] = vecs[v].b;
            imem[0] = ins(OP_LI, 3, 1);
            imem[1] = ins(OP_LD, 1, 3);
            imem[2] = ins(OP_LI, 3, 2);
            imem[3] = ins(OP_LD, 2, 3);
            if (vecs[v].op == OP_ADDI || vecs[v].op == OP_LI)
                imem[4] = ins(vecs[v].op, 1, int'(vecs[v].b) % 8);
            else
                imem[4] = ins(vecs[v].op, 1, 2);
            imem[5] = ins(OP_ST, 1, 0);
            exp_q.push_back('{1'b0, 10'd1, 10'd0});
            exp_q.push_back('{1'b0, 10'd2, 10'd0});
            exp_q.push_back('{1'b1, 10'd0, vecs[v].exp});
            rst_off();
            wait_done($sformatf("vec%0d", v), 300);
            chk($sformatf("vec%0d illegal", v), 32'(illegal), 32'd0);
            chk($sformatf("vec%0d fetches", v), 32'(n_fetch - f0), 32'd7);
            chk($sformatf("vec%0d LD latency", v), 32'(fcyc(2) - fcyc(1)), 32'd4);
            chk($sformatf("vec%0d op latency", v), 32'(fcyc(5) - fcyc(4)), 32'd3);
            chk($sformatf("vec%0d ST latency", v), 32'(fcyc(6) - fcyc(5)), 32'd3);
            check_accs($sformatf("vec%0d", v));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
